// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike events per channel over a programmable
// window of clk cycles and presents the per-channel totals through a
// valid/ready output register with a sticky overrun flag.
//
// Optional feature macro: SPIKE_EDGE_DETECT_EN
//   defined   -> a spike event is a 0->1 transition of spike_in[i]
//   undefined -> a spike event is any COUNT cycle with spike_in[i] high
module spike_rate_decoder #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]        win_len,
  output logic [NUM_CH*CNT_W-1:0] rate_out,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic [WIN_W-1:0]          cyc_q, cyc_d;
  logic [CNT_W-1:0]          cnt_q [NUM_CH];
  logic [CNT_W-1:0]          cnt_d [NUM_CH];
  logic [NUM_CH*CNT_W-1:0]   rate_q, rate_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic [NUM_CH-1:0]         event_s;
  logic                      done_s;
  logic                      hs_s;
  logic                      last_s;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

`ifdef SPIKE_EDGE_DETECT_EN
  logic [NUM_CH-1:0] hist_q;

  // Previous-cycle spike levels, tracked in every state so a level already
  // high when a window opens is not miscounted as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= {NUM_CH{1'b0}};
    end else begin
      hist_q <= spike_in;
    end
  end

  assign event_s = spike_in & ~hist_q;
`else
  assign event_s = spike_in;
`endif

  assign last_s = (cyc_q == (win_q - WIN_ONE));
  assign hs_s   = valid_q & rate_ready;

  // Window FSM: next state, window/cycle bookkeeping and per-channel counts.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d = WIN_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
          cnt_d[i] = CNT_ZERO;
        end
        if (ena && (win_len != WIN_ZERO)) begin
          state_d = ST_COUNT;
          win_d   = win_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!ena || (win_q == WIN_ZERO)) begin
          // Abandon the partial window; results and flags are untouched.
          state_d = ST_IDLE;
          cyc_d   = WIN_ZERO;
          for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = CNT_ZERO;
          end
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = sat_inc(cnt_q[i], event_s[i]);
          end
          if (last_s) begin
            // Last cycle's events are included in the published totals;
            // the next window starts on the following cycle with no gap.
            done_s = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
              rate_d[i*CNT_W +: CNT_W] = cnt_d[i];
              cnt_d[i]                 = CNT_ZERO;
            end
            cyc_d = WIN_ZERO;
            win_d = win_len;
          end else begin
            cyc_d = cyc_q + WIN_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = WIN_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
          cnt_d[i] = CNT_ZERO;
        end
      end
    endcase
  end

  // Output handshake: completion wins over consumption; overrun records a
  // result lost because the previous one was still pending.
  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (done_s) begin
      valid_d = 1'b1;
      ovr_d   = ovr_q | (valid_q & ~rate_ready);
    end else if (hs_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= WIN_ZERO;
      cyc_q   <= WIN_ZERO;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      rate_q  <= {(NUM_CH*CNT_W){1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: directed scenarios with hand-derived
// expectations plus a randomized run checked against a behavioural model.
module tb_spike_rate_decoder;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int WIN_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef SPIKE_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic                    ena;
  logic [NUM_CH-1:0]       spike_in;
  logic [WIN_W-1:0]        win_len;
  logic [NUM_CH*CNT_W-1:0] rate_out;
  logic                    rate_valid;
  logic                    rate_ready;
  logic                    overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_active;
  int m_len, m_pos;
  int m_cnt  [NUM_CH];
  int m_rate [NUM_CH];
  bit m_prev [NUM_CH];
  bit m_valid, m_ovr;

  spike_rate_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .win_len   (win_len),
    .rate_out  (rate_out),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ch(input int i);
    return int'(rate_out[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_len = 0; m_pos = 0;
    m_valid = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_rate[i] = 0; m_prev[i] = 1'b0;
    end
  endtask

  // One clock of the decoder's rules, applied to the inputs about to be sampled.
  task automatic model_step();
    bit ev [NUM_CH];
    bit hs, done;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i] = EDGE ? (spike_in[i] && !m_prev[i]) : spike_in[i];
      m_prev[i] = spike_in[i];
    end
    hs = m_valid && rate_ready;
    done = 1'b0;
    if (!m_active) begin
      if (ena && win_len != 0) begin
        m_active = 1'b1; m_len = int'(win_len); m_pos = 0;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      end
    end else if (!ena || m_len == 0) begin
      m_active = 1'b0; m_pos = 0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (ev[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      if (m_pos == m_len - 1) begin
        done = 1'b1;
        m_rate = m_cnt;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_len = int'(win_len); m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    if (done) begin
      if (m_valid && !hs) m_ovr = 1'b1;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ena = 1'b0; rate_ready = 1'b1; spike_in = 3'b000;
    tick(); tick();
    rate_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; rate_ready = 1'b0; spike_in = 3'b000; win_len = 8'd0;
    model_reset();
    tick(); tick();
    n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rate_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_tests++; if (rate_out !== 24'd0) begin n_fail++; $display("FAIL reset_rate: got %h want 0", rate_out); end
    rst_n = 1'b1;
    tick();
    ena = 1'b1; win_len = 8'd4;
    tick();                       // window entry
    tick(); tick(); tick();       // window cycles 0..2
    n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL first_win_early: got %b want 0", rate_valid); end
    tick();                       // window cycle 3
    n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL first_win_valid: got %b want 1", rate_valid); end
    n_tests++; if (rate_out !== 24'd0) begin n_fail++; $display("FAIL first_win_rate: got %h want 0", rate_out); end
    go_idle();
  endtask

  task automatic test_counting();
    int exp2;
    exp2 = EDGE ? 1 : 7;
    ena = 1'b1; win_len = 8'd10; rate_ready = 1'b1; spike_in = 3'b000;
    tick();
    for (int c = 0; c < 10; c++) begin
      spike_in[0] = (c == 1 || c == 4 || c == 7);
      spike_in[1] = 1'b0;
      spike_in[2] = (c < 7);
      tick();
    end
    spike_in = 3'b000;
    n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL count_valid: got %b want 1", rate_valid); end
    n_tests++; if (ch(0) != 3) begin n_fail++; $display("FAIL count_ch0: got %0d want 3", ch(0)); end
    n_tests++; if (ch(1) != 0) begin n_fail++; $display("FAIL count_ch1: got %0d want 0", ch(1)); end
    n_tests++; if (ch(2) != exp2) begin n_fail++; $display("FAIL count_ch2: got %0d want %0d", ch(2), exp2); end
    tick();
    n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL count_valid_pulse: got %b want 0", rate_valid); end
    go_idle();
  endtask

  task automatic test_saturation();
    int exp1;
    exp1 = EDGE ? 1 : 255;
    ena = 1'b1; win_len = 8'd255; rate_ready = 1'b1; spike_in = 3'b000;
    tick();
    for (int c = 0; c < 255; c++) begin
      spike_in[0] = (c % 2 == 0);
      spike_in[1] = 1'b1;
      spike_in[2] = 1'b0;
      tick();
    end
    spike_in = 3'b000;
    n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b want 1", rate_valid); end
    n_tests++; if (ch(1) != exp1) begin n_fail++; $display("FAIL sat_ch1: got %0d want %0d", ch(1), exp1); end
    n_tests++; if (ch(0) != 128) begin n_fail++; $display("FAIL sat_ch0_toggle: got %0d want 128", ch(0)); end
    go_idle();
  endtask

  task automatic test_overrun();
    ena = 1'b1; win_len = 8'd5; rate_ready = 1'b0; spike_in = 3'b000;
    tick();
    for (int c = 0; c < 5; c++) begin spike_in[0] = (c == 1); tick(); end
    n_tests++; if (rate_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got v=%b o=%b want v=1 o=0", rate_valid, overrun); end
    n_tests++; if (ch(0) != 1) begin n_fail++; $display("FAIL ovr_first_ch0: got %0d want 1", ch(0)); end
    for (int c = 0; c < 5; c++) begin spike_in[0] = (c % 2 == 0); tick(); end
    spike_in = 3'b000;
    n_tests++; if (rate_valid !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_second: got v=%b o=%b want v=1 o=1", rate_valid, overrun); end
    n_tests++; if (ch(0) != 3) begin n_fail++; $display("FAIL ovr_second_ch0: got %0d want 3", ch(0)); end
    ena = 1'b0; rate_ready = 1'b1;
    tick();
    n_tests++; if (rate_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got v=%b o=%b want v=0 o=0", rate_valid, overrun); end
    rate_ready = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    // rate_out still holds ch0=3 from the overrun scenario
    ena = 1'b1; win_len = 8'd8; rate_ready = 1'b0; spike_in = 3'b000;
    tick();
    for (int c = 0; c < 3; c++) begin spike_in[1] = (c == 1); tick(); end
    ena = 1'b0; spike_in = 3'b000;
    for (int k = 0; k < 8; k++) tick();
    n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL ena_drop_valid: got %b want 0", rate_valid); end
    n_tests++; if (ch(0) != 3 || ch(1) != 0) begin n_fail++; $display("FAIL ena_drop_hold: got ch0=%0d ch1=%0d want 3 0", ch(0), ch(1)); end
    // win_len change mid-window applies only to the next window
    ena = 1'b1; win_len = 8'd8; rate_ready = 1'b1;
    tick();
    for (int c = 0; c < 7; c++) begin
      if (c == 2) win_len = 8'd3;
      tick();
    end
    n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL winchg_early: got %b want 0", rate_valid); end
    tick();
    n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL winchg_end8: got %b want 1", rate_valid); end
    tick();
    rate_ready = 1'b0;
    tick();
    n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL winchg_mid3: got %b want 0", rate_valid); end
    tick();
    n_tests++; if (rate_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL winchg_end3: got v=%b o=%b want v=1 o=0", rate_valid, overrun); end
    // completion coinciding with a handshake
    spike_in = 3'b100; tick();
    spike_in = 3'b000; tick();
    rate_ready = 1'b1; tick();
    n_tests++; if (rate_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL hs_complete: got v=%b o=%b want v=1 o=0", rate_valid, overrun); end
    n_tests++; if (ch(2) != 1 || ch(0) != 0) begin n_fail++; $display("FAIL hs_complete_data: got ch2=%0d ch0=%0d want 1 0", ch(2), ch(0)); end
    go_idle();
  endtask

  task automatic test_async_reset();
    ena = 1'b1; win_len = 8'd6; rate_ready = 1'b0; spike_in = 3'b001;
    for (int k = 0; k < 10; k++) tick();
    n_tests++; if (rate_valid !== 1'b1 || rate_out === 24'd0) begin n_fail++; $display("FAIL arst_pre: got v=%b rate=%h want v=1 rate!=0", rate_valid, rate_out); end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (rate_valid !== 1'b0 || overrun !== 1'b0 || rate_out !== 24'd0) begin n_fail++; $display("FAIL arst_async: got v=%b o=%b rate=%h want all 0", rate_valid, overrun, rate_out); end
    tick();
    rst_n = 1'b1; spike_in = 3'b000;
    go_idle();
  endtask

  task automatic test_random();
    logic [NUM_CH*CNT_W-1:0] exp_v;
    int bad;
    bad = 0;
    ena = 1'b1; win_len = 8'd5;
    for (int k = 0; k < 3000; k++) begin
      ena = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0) win_len = 8'($urandom_range(0, 12));
      spike_in = 3'($urandom);
      rate_ready = ($urandom_range(0, 3) == 0);
      tick();
      for (int i = 0; i < NUM_CH; i++) exp_v[i*CNT_W +: CNT_W] = 8'(m_rate[i]);
      n_tests++;
      if (rate_valid !== m_valid || overrun !== m_ovr || rate_out !== exp_v) begin
        n_fail++;
        if (bad < 10) $display("FAIL rand_cycle%0d: got v=%b o=%b rate=%h want v=%b o=%b rate=%h",
                               k, rate_valid, overrun, rate_out, m_valid, m_ovr, exp_v);
        bad++;
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_counting();
    test_saturation();
    test_overrun();
    test_enable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter NUM_CH, default 3: number of spike input channels.
REQ-002 Parameter CNT_W, default 8: width of each per-channel rate count.
REQ-003 Parameter WIN_W, default 8: width of the window-length input.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 ena  input  1: decoder enable, active high.
REQ-007 spike_in  input  NUM_CH: spike lines from the LIF neurons, bit i is channel i.
REQ-008 win_len  input  WIN_W: counting window length in clk cycles.
REQ-009 rate_out  output  NUM_CH*CNT_W: per-channel spike counts of the last completed window, channel i at bits [i*CNT_W +: CNT_W].
REQ-010 rate_valid  output  1: rate_out holds an unconsumed result.
REQ-011 rate_ready  input  1: consumer accepts rate_out when rate_valid and rate_ready are both high on a clk edge.
REQ-012 overrun  output  1: sticky flag; an unconsumed result was overwritten.

Function
REQ-013 The decoder SHALL have two states, IDLE and COUNT.
REQ-014 IDLE -> COUNT when ena=1 and win_len!=0; on entry, win_len is captured into an internal window register and the cycle counter is set to 0.
REQ-015 COUNT -> IDLE when ena=0 or the captured length is 0; all per-channel counters and the cycle counter clear; rate_out, rate_valid and overrun hold.
REQ-016 Changes to win_len during a window SHALL take effect only at the next window start.
REQ-017 Each COUNT cycle, channel i's counter increments by 1 when a spike event is present on bit i (see REQ-027/028); it saturates at 2^CNT_W-1 and does not wrap.
REQ-018 The cycle counter runs 0..captured_len-1; the cycle with count captured_len-1 is the window's last cycle and SHALL include that cycle's spike events.
REQ-019 At the end of the last cycle, all channel totals latch into rate_out and rate_valid=1 in the next cycle (latency: 1 clk after the last window cycle).
REQ-020 After the last cycle, the counters clear, win_len is re-captured, and the next window starts immediately with no gap cycle.
REQ-021 rate_valid SHALL stay high with rate_out stable until a handshake occurs; the handshake clears rate_valid on the next edge.
REQ-022 If a window completes while rate_valid=1 and no handshake occurs that cycle, rate_out is overwritten, rate_valid stays 1 and overrun is set to 1.
REQ-023 If a window completes in the same cycle as a handshake, new data loads, rate_valid stays 1 and overrun is not set.
REQ-024 overrun SHALL clear on the next handshake that coincides with no window completion.

Reset
REQ-025 While rst_n=0, all of the following SHALL be forced immediately, independent of clk:
- state=IDLE
- rate_out=0, rate_valid=0, overrun=0
- all counters=0
- edge-detect history=0
REQ-026 Reset mid-window SHALL discard partial counts; the first window after release starts per REQ-014.

Configuration
REQ-027 With SPIKE_EDGE_DETECT_EN defined, a spike event is a 0->1 transition of spike_in[i] against its registered previous value. The history register updates every cycle regardless of state; a spike held high counts once.
REQ-028 Without SPIKE_EDGE_DETECT_EN, a spike event is every COUNT cycle in which spike_in[i]=1, and no history register exists.

Verification
REQ-029 Reset: rst_n=0 asserted asynchronously mid-window -> all outputs 0 within the same cycle; after release with ena=1, win_len=4, no spikes -> rate_valid=1 with rate_out=0 one cycle after the 4th window cycle.
REQ-030 Counting: win_len=10, channel 0 pulsed 3 single-cycle spikes, channel 2 pulsed 7, rate_ready=1 -> rate_out ch0=3, ch1=0, ch2=7, rate_valid high for exactly 1 cycle.
REQ-031 Saturation: CNT_W=8, win_len=0 then 255 with spike_in[1] toggled every cycle for 300 windows' worth of cycles (level mode) -> no wrap. Without SPIKE_EDGE_DETECT_EN, spike_in held 1, win_len=255 -> ch1=255.
REQ-032 Overrun: rate_ready=0, win_len=5, two windows complete -> rate_valid=1, overrun=1, rate_out=2nd window counts. Next handshake with no completion -> rate_valid=0, overrun=0.
REQ-033 Edge mode (SPIKE_EDGE_DETECT_EN): spike_in[0] held high for 6 cycles within a win_len=8 window -> ch0=1. Without the macro, the same stimulus -> ch0=6.
REQ-034 Enable/boundary: ena dropped after cycle 3 of an 8-cycle window -> no result, previous rate_out held. win_len changed 8->3 mid-window -> current window ends at 8 and the next at 3. Window completion coinciding with a handshake -> new data, overrun=0.
